rbus_rx_sink: RTL and testbench
===============================

# rbus_rx_sink

Terminating receiver for one rbus channel: the far end of the rbus N-to-M interconnect. It accepts rbus packets (`stb`/`sof`/72-bit data), steers them into one of two per-class word buffers, and advertises space and emptiness upstream through `rdy[1:0]` and `rdyE[1:0]`. Buffered packets are presented to local logic on a word-wide valid/ack port, with strict priority for class 1 and no interleaving within a packet. Protocol violations raise a sticky `ff_err`.

## Interface
- `DEPTH`, 32: words per class buffer; power of 2, minimum 16.
- `MAXW`, 9: maximum packet length in words, header plus 8 payload words.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_stb` in 1: word valid on the rbus input.
- `i_sof` in 1: first (header) word of a packet.
- `i_data` in 72: word data. On header words, `[71:68]` = payload word count LEN (0..8) and `[67]` = class.
- `i_rdy` out 2: bit k = class k can accept a new max-length packet.
- `i_rdyE` out 2: bit k = class k buffer empty and no class k packet in flight.
- `o_valid` out 1: local word valid.
- `o_sof` out 1: local word is a header.
- `o_eof` out 1: local word is the last word of its packet.
- `o_cls` out 1: class of the current word.
- `o_data` out 72: local word data.
- `o_ack` in 1: local consumer takes the word (valid only with `o_valid`).
- `ff_err` out 1: sticky protocol/overflow error.

## Operation

**Input side**
- A header word is accepted when `i_stb & i_sof`. It latches `cls = i_data[67]` and `remaining = LEN`.
- Each following `i_stb` word with `i_sof=0` goes to the same class while `remaining > 0`.
- When `remaining` reaches 0, the current word is written with `eof=1`. A header with LEN=0 is written with `sof=1` and `eof=1`.
- Each buffer entry is 74 bits: `{sof, eof, data}`.

**Sender rule**
- The sender may drive a class-k header in cycle t only if `i_rdy[k]=1` in cycle t.
- After a header, the sender may send payload words at any rate; the sink never stalls mid-packet.

**Space accounting, per class**
- `avail = DEPTH - count - (in-flight packet of this class ? MAXW - words_written_so_far : 0)`.
- `i_rdy[k]` is a register loaded each edge with `(avail_next >= MAXW)`.
- Therefore a header at edge E is reflected in `i_rdy` immediately after E. Back-to-back headers are safe.

**Errors (set `ff_err`, which clears only on `rst`)**
- `i_stb & ~i_sof` while no packet is in flight: the word is dropped.
- `i_sof` while `remaining > 0`: the old packet is closed, with its last written word keeping `eof=0`, and the new packet is started.
- LEN > 8: treated as 8.
- Header for class k while `i_rdy[k]=0`.
- Write to a full buffer: the word is dropped.

**Output side**
- Two-state FSM: IDLE and LOCK(c).
- IDLE: if the class 1 head is valid, go to LOCK(1); else if the class 0 head is valid, go to LOCK(0).
- LOCK(c): present class c words only. Return to IDLE on the acked word with `eof=1`.
- Cut-through: LOCK may wait on an empty buffer mid-packet (`o_valid=0`) until more words arrive.
- `o_*` come from an output register. `o_data`/`o_sof`/`o_eof`/`o_cls` hold while `o_valid & ~o_ack`.

## Timing
- Reset values:
  - `i_rdy=2'b00`, then `2'b11` after the first edge following `rst` release.
  - `i_rdyE=2'b11`.
  - `o_valid=0`, `o_sof=0`, `o_eof=0`, `o_cls=0`, `o_data=0`, `ff_err=0`.
- Latency:
  - A word accepted at edge E into an idle path appears on `o_valid` after edge E+1 (2 cycles from input to output).
  - With `o_ack` held high, the output sustains 1 word per cycle.
- `i_rdyE[k]`:
  - Registered.
  - Falls after the edge accepting a class-k header.
  - Rises after the edge at which the final class-k word leaves the output register while no class-k packet is in flight.
- Simultaneous write and read on one buffer: `count` is unchanged.
- Buffer pointers wrap modulo DEPTH.
- `rst` mid-packet: all buffers and in-flight state are flushed. The partial packet is lost with no error.

## Structure
- Package `rbus_pkg`:
  - `RBUS_W=72`.
  - Header field constants `LEN_HI=71`, `LEN_LO=68`, `CLS_BIT=67`.
  - `MAXW_DEF=9`.
  - Entry typedef `{sof, eof, data}`.
- Sub-module `rbus_rx_fifo`:
  - Synchronous FIFO with DEPTH×74 entries.
  - Provides `count`, `full`, `empty`, and a first-word output.
  - Instantiated twice, once per class.
- Top level holds the input tracker, space/`rdy` logic, output FSM, and `ff_err`.

## Test plan
- Reset, then a class 0 header with LEN=2 plus 2 payload words at t=0..2, `o_ack=1` → 3 words out starting at t=2; `sof` on the first, `eof` on the third; `i_rdyE[0]` back to 1 afterwards.
- Fill class 0 with LEN=8 packets, no ack, DEPTH=32 → `i_rdy[0]` falls after the 3rd header (32-27=5 < 9); `i_rdy[1]` stays 1; `ff_err` stays 0.
- Class 0 packet, then a class 1 packet while the class 0 packet is mid-read → class 0 finishes, then class 1, with no interleave. When both are pending in IDLE, class 1 goes first.
- Payload word with no preceding header, then a header with LEN=12 → `ff_err` set; the stray word is dropped; 9 words delivered with `eof` on the 9th.
- `o_ack` toggled at random over a 100-packet random stream → per-class word order and data preserved; `ff_err` stays 0.
- Assert `rst` mid-packet → all outputs at reset values; the next clean packet passes intact.

Source files
------------

// File: rtl/rbus_pkg.sv
// rbus_pkg: shared rbus widths, header field positions and buffer entry type
package rbus_pkg;

    localparam int RBUS_W   = 72;
    localparam int LEN_HI   = 71;
    localparam int LEN_LO   = 68;
    localparam int CLS_BIT  = 67;
    localparam int MAXW_DEF = 9;

    typedef struct packed {
        logic              sof;
        logic              eof;
        logic [RBUS_W-1:0] data;
    } entry_t;

    typedef enum logic {
        IDLE,
        LOCK
    } ostate_t;

endpackage

// File: rtl/rbus_rx_sink_if.sv
// rbus_rx_sink_if: rbus input channel plus local word-wide valid/ack port
interface rbus_rx_sink_if;

    logic                      i_stb;
    logic                      i_sof;
    logic [rbus_pkg::RBUS_W-1:0] i_data;
    logic [1:0]                i_rdy;
    logic [1:0]                i_rdyE;
    logic                      o_valid;
    logic                      o_sof;
    logic                      o_eof;
    logic                      o_cls;
    logic [rbus_pkg::RBUS_W-1:0] o_data;
    logic                      o_ack;
    logic                      ff_err;

    modport master (
        output i_stb, i_sof, i_data, o_ack,
        input  i_rdy, i_rdyE, o_valid, o_sof, o_eof, o_cls, o_data, ff_err
    );

    modport slave (
        input  i_stb, i_sof, i_data, o_ack,
        output i_rdy, i_rdyE, o_valid, o_sof, o_eof, o_cls, o_data, ff_err
    );

endinterface

// File: rtl/rbus_rx_fifo.sv
// rbus_rx_fifo: show-ahead word buffer for one rbus class, drops writes when full
module rbus_rx_fifo import rbus_pkg::*; #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     rd,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic            wok;
    logic            rok;

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wok   = wr & ~full;
    assign rok   = rd & ~empty;
    assign dout  = mem[rp];

    // storage array, written only when there is room
    always_ff @(posedge clk) begin
        if (wok) mem[wp] <= din;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wok) wp <= wp + 1'b1;
            if (rok) rp <= rp + 1'b1;
            count <= count + CW'(wok) - CW'(rok);
        end
    end

endmodule

// File: rtl/rbus_rx_sink.sv
// rbus_rx_sink: rbus channel terminator with per-class buffers and priority local output
module rbus_rx_sink import rbus_pkg::*; #(
    parameter int DEPTH = 32,
    parameter int MAXW  = MAXW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    rbus_rx_sink_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAXW + 1);

    logic [3:0]        rem;
    logic [3:0]        rem_n;
    logic [3:0]        hlen;
    logic              cur;
    logic              cur_n;
    logic [WW-1:0]     wcnt;
    logic [WW-1:0]     wcnt_n;
    logic              hdr;
    logic              pay;
    logic              hcls;
    logic              wcls;
    logic              wreq;
    logic              len_big;
    logic              err;
    logic              err_n;
    logic [1:0]        wr;
    logic [1:0]        wok;
    logic [1:0]        rd;
    logic [1:0]        full;
    logic [1:0]        empty;
    logic [1:0]        rdy;
    logic [1:0]        rdy_n;
    logic [1:0]        rdye;
    logic [1:0]        rdye_n;
    entry_t            din;
    entry_t            hd;
    entry_t            head [2];
    logic [CW-1:0]     cnt  [2];
    logic [CW-1:0]     cn   [2];
    ostate_t           st;
    ostate_t           st_n;
    logic              lc;
    logic              lc_n;
    logic              ld;
    logic              sel;
    logic              pop;
    logic              ov;
    logic              ov_n;
    logic              oc_n;
    logic              osof;
    logic              oeof;
    logic              ocls;
    logic [RBUS_W-1:0] odat;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        rbus_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (wr[g]),
            .rd    (rd[g]),
            .din   (din),
            .dout  (head[g]),
            .count (cnt[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    assign wok         = wr & ~full;
    assign bus.i_rdy   = rdy;
    assign bus.i_rdyE  = rdye;
    assign bus.o_valid = ov;
    assign bus.o_sof   = osof;
    assign bus.o_eof   = oeof;
    assign bus.o_cls   = ocls;
    assign bus.o_data  = odat;
    assign bus.ff_err  = err;

    // input tracker: steer words to a class buffer, mark eof, flag protocol errors
    always_comb begin
        hdr     = bus.i_stb & bus.i_sof;
        pay     = bus.i_stb & ~bus.i_sof;
        len_big = bus.i_data[LEN_HI:LEN_LO] > 4'd8;
        hlen    = len_big ? 4'd8 : bus.i_data[LEN_HI:LEN_LO];
        hcls    = bus.i_data[CLS_BIT];
        wcls    = hdr ? hcls : cur;
        wreq    = hdr | (pay & (rem != 4'd0));
        wr      = wreq ? (wcls ? 2'b10 : 2'b01) : 2'b00;
        din     = {hdr, hdr ? (hlen == 4'd0) : (rem == 4'd1), bus.i_data};
        rem_n   = hdr ? hlen : (pay && rem != 4'd0) ? rem - 4'd1 : rem;
        cur_n   = hdr ? hcls : cur;
        wcnt_n  = hdr ? WW'(1) : wreq ? wcnt + 1'b1 : wcnt;
        err_n   = err
                | (hdr & ((rem != 4'd0) | len_big | ~rdy[hcls]))
                | (pay & (rem == 4'd0))
                | (wreq & full[wcls]);
    end

    // output FSM: pick a class at packet start, then stay on it until its eof is popped
    always_comb begin
        ld   = ~ov | bus.o_ack;
        sel  = (st == LOCK) ? lc : ~empty[1];
        pop  = ld & ~empty[sel];
        rd   = {pop & sel, pop & ~sel};
        hd   = head[sel];
        st_n = pop ? (hd.eof ? IDLE : LOCK) : st;
        lc_n = pop ? sel : lc;
        ov_n = ld ? pop : ov;
        oc_n = pop ? sel : ocls;
    end

    // space and emptiness advertised from next-cycle occupancy plus in-flight reservation
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cn[k]     = cnt[k] + CW'(wok[k]) - CW'(rd[k]);
            rdy_n[k]  = int'(cn[k])
                      + ((rem_n != 4'd0 && cur_n == 1'(k)) ? MAXW - int'(wcnt_n) : 0)
                      + MAXW <= DEPTH;
            rdye_n[k] = cn[k] == '0
                      && !(rem_n != 4'd0 && cur_n == 1'(k))
                      && !(ov_n && oc_n == 1'(k));
        end
    end

    // input tracker, advertisement and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            cur  <= 1'b0;
            wcnt <= '0;
            err  <= 1'b0;
            rdy  <= 2'b00;
            rdye <= 2'b11;
        end else begin
            rem  <= rem_n;
            cur  <= cur_n;
            wcnt <= wcnt_n;
            err  <= err_n;
            rdy  <= rdy_n;
            rdye <= rdye_n;
        end
    end

    // output FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            lc <= 1'b0;
        end else begin
            st <= st_n;
            lc <= lc_n;
        end
    end

    // output word register, holds contents while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov   <= 1'b0;
            osof <= 1'b0;
            oeof <= 1'b0;
            ocls <= 1'b0;
            odat <= '0;
        end else begin
            ov <= ov_n;
            if (pop) begin
                osof <= hd.sof;
                oeof <= hd.eof;
                ocls <= sel;
                odat <= hd.data;
            end
        end
    end

endmodule

// File: tb/tb_rbus_rx_sink.sv
// tb_rbus_rx_sink: randomized scoreboard bench for the rbus terminating receiver
module tb_rbus_rx_sink;
    import rbus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rbus_rx_sink_if bus();

    rbus_rx_sink #(.DEPTH(32), .MAXW(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         total = 0;
    int         bad   = 0;
    logic [73:0] q0 [$];
    logic [73:0] q1 [$];
    bit         cls_log [$];
    bit         ack_rand = 1'b0;
    bit         in_pkt   = 1'b0;
    bit         pkt_cls  = 1'b0;

    // scoreboard: every consumed word must be the next expected word of its class
    always @(negedge clk) begin
        logic [73:0] got;
        logic [73:0] exp;
        if (rst) begin
            in_pkt = 1'b0;
        end else if (bus.o_valid === 1'b1 && bus.o_ack === 1'b1) begin
            got = {bus.o_sof, bus.o_eof, bus.o_data};
            cls_log.push_back(bus.o_cls);
            total++;
            if ((bus.o_cls ? q1.size() : q0.size()) == 0) begin
                bad++;
                $display("FAIL word_unexpected: cls=%0d got=%h required no word", bus.o_cls, got);
            end else begin
                exp = bus.o_cls ? q1.pop_front() : q0.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL word_data: cls=%0d got=%h required %h", bus.o_cls, got, exp);
                end
            end
            if (in_pkt) begin
                total++;
                if (bus.o_cls !== pkt_cls) begin
                    bad++;
                    $display("FAIL interleave: cls=%0d required %0d", bus.o_cls, pkt_cls);
                end
            end
            in_pkt  = !bus.o_eof;
            pkt_cls = bus.o_cls;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
        if (ack_rand) bus.o_ack = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [71:0] rnd72();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[71:0];
    endfunction

    task automatic idle_in;
        bus.i_stb = 1'b0;
        bus.i_sof = 1'b0;
    endtask

    task automatic drive(input bit s, input logic [71:0] d);
        bus.i_stb  = 1'b1;
        bus.i_sof  = s;
        bus.i_data = d;
    endtask

    task automatic push_exp(input bit c, input logic [73:0] e);
        if (c) q1.push_back(e);
        else   q0.push_back(e);
    endtask

    task automatic send_pkt(input bit c, input int len, input int gap);
        logic [71:0] d;
        int n;
        int w;
        n = len > 8 ? 8 : len;
        w = 0;
        while (bus.i_rdy[c] !== 1'b1 && w < 5000) begin
            idle_in();
            tick();
            w++;
        end
        if (bus.i_rdy[c] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL rdy_wait: i_rdy[%0d]=%b required 1 within bound", c, bus.i_rdy[c]);
            return;
        end
        d = rnd72();
        d[71:68] = 4'(len);
        d[67] = c;
        push_exp(c, {1'b1, n == 0, d});
        drive(1'b1, d);
        tick();
        for (int i = 1; i <= n; i++) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) begin
                idle_in();
                tick();
            end
            d = rnd72();
            push_exp(c, {1'b0, i == n, d});
            drive(1'b0, d);
            tick();
        end
        idle_in();
    endtask

    task automatic wait_drain;
        ack_rand  = 1'b0;
        bus.o_ack = 1'b1;
        idle_in();
        for (int i = 0; i < 3000 && (q0.size() != 0 || q1.size() != 0); i++) tick();
        tick();
        tick();
        total++;
        if (q0.size() + q1.size() != 0 || bus.o_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: pending=%0d o_valid=%b required 0 and 0", q0.size() + q1.size(), bus.o_valid);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        q0.delete();
        q1.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        bus.i_stb  = 1'b0;
        bus.i_sof  = 1'b0;
        bus.i_data = '0;
        bus.o_ack  = 1'b0;
        repeat (2) tick();
        total++;
        if (bus.i_rdy !== 2'b00) begin bad++; $display("FAIL rst_rdy: got=%b required 00", bus.i_rdy); end
        total++;
        if (bus.i_rdyE !== 2'b11) begin bad++; $display("FAIL rst_rdyE: got=%b required 11", bus.i_rdyE); end
        total++;
        if ({bus.o_valid, bus.o_sof, bus.o_eof, bus.o_cls, bus.ff_err} !== 5'b0) begin
            bad++;
            $display("FAIL rst_ctrl: got=%b required 00000", {bus.o_valid, bus.o_sof, bus.o_eof, bus.o_cls, bus.ff_err});
        end
        total++;
        if (bus.o_data !== 72'h0) begin bad++; $display("FAIL rst_data: got=%h required 0", bus.o_data); end
        rst = 1'b0;
        total++;
        if (bus.i_rdy !== 2'b00) begin bad++; $display("FAIL rdy_release: got=%b required 00", bus.i_rdy); end
        tick();
        total++;
        if (bus.i_rdy !== 2'b11) begin bad++; $display("FAIL rdy_first_edge: got=%b required 11", bus.i_rdy); end
    endtask

    task automatic test_basic;
        logic [71:0] d0;
        logic [71:0] d1;
        logic [71:0] d2;
        bus.o_ack = 1'b1;
        d0 = rnd72();
        d0[71:68] = 4'd2;
        d0[67] = 1'b0;
        d1 = rnd72();
        d2 = rnd72();
        q0.push_back({2'b10, d0});
        q0.push_back({2'b00, d1});
        q0.push_back({2'b01, d2});
        drive(1'b1, d0);
        tick();
        drive(1'b0, d1);
        total++;
        if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL basic_lat: o_valid=%b required 0", bus.o_valid); end
        total++;
        if (bus.i_rdyE[0] !== 1'b0) begin bad++; $display("FAIL basic_rdyE_fall: got=%b required 0", bus.i_rdyE[0]); end
        tick();
        drive(1'b0, d2);
        total++;
        if ({bus.o_valid, bus.o_sof, bus.o_eof, bus.o_data} !== {3'b110, d0}) begin
            bad++;
            $display("FAIL basic_w0: got=%b%b%b %h required 110 %h", bus.o_valid, bus.o_sof, bus.o_eof, bus.o_data, d0);
        end
        tick();
        idle_in();
        total++;
        if ({bus.o_valid, bus.o_sof, bus.o_eof, bus.o_data} !== {3'b100, d1}) begin
            bad++;
            $display("FAIL basic_w1: got=%b%b%b %h required 100 %h", bus.o_valid, bus.o_sof, bus.o_eof, bus.o_data, d1);
        end
        tick();
        total++;
        if ({bus.o_valid, bus.o_sof, bus.o_eof, bus.o_data} !== {3'b101, d2}) begin
            bad++;
            $display("FAIL basic_w2: got=%b%b%b %h required 101 %h", bus.o_valid, bus.o_sof, bus.o_eof, bus.o_data, d2);
        end
        tick();
        total++;
        if (bus.o_valid !== 1'b0 || bus.i_rdyE[0] !== 1'b1) begin
            bad++;
            $display("FAIL basic_end: o_valid=%b rdyE0=%b required 0 1", bus.o_valid, bus.i_rdyE[0]);
        end
    endtask

    task automatic test_fill;
        logic [71:0] d;
        bus.o_ack = 1'b0;
        ack_rand  = 1'b0;
        for (int h = 0; h < 3; h++) begin
            total++;
            if (bus.i_rdy[0] !== 1'b1) begin bad++; $display("FAIL fill_pre%0d: rdy0=%b required 1", h, bus.i_rdy[0]); end
            d = rnd72();
            d[71:68] = 4'd8;
            d[67] = 1'b0;
            q0.push_back({2'b10, d});
            drive(1'b1, d);
            tick();
            total++;
            if (bus.i_rdy[0] !== 1'(h < 2)) begin bad++; $display("FAIL fill_rdy0_%0d: got=%b required %b", h, bus.i_rdy[0], 1'(h < 2)); end
            total++;
            if (bus.i_rdy[1] !== 1'b1) begin bad++; $display("FAIL fill_rdy1_%0d: got=%b required 1", h, bus.i_rdy[1]); end
            for (int p = 1; p <= 8; p++) begin
                d = rnd72();
                q0.push_back({1'b0, p == 8, d});
                drive(1'b0, d);
                tick();
            end
        end
        idle_in();
        tick();
        total++;
        if (bus.ff_err !== 1'b0) begin bad++; $display("FAIL fill_err: got=%b required 0", bus.ff_err); end
        wait_drain();
    endtask

    task automatic test_priority;
        int start;
        bit order [3];
        start    = cls_log.size();
        ack_rand = 1'b1;
        send_pkt(1'b0, 6, 0);
        send_pkt(1'b1, 3, 0);
        wait_drain();
        total++;
        if (cls_log.size() - start != 11) begin
            bad++;
            $display("FAIL lock_count: got=%0d required 11", cls_log.size() - start);
        end else begin
            for (int i = 0; i < 11; i++) begin
                total++;
                if (cls_log[start + i] !== 1'(i >= 7)) begin
                    bad++;
                    $display("FAIL lock_order%0d: cls=%0d required %0d", i, cls_log[start + i], i >= 7);
                end
            end
        end
        bus.o_ack = 1'b0;
        start = cls_log.size();
        send_pkt(1'b0, 0, 0);
        send_pkt(1'b0, 0, 0);
        send_pkt(1'b1, 0, 0);
        repeat (3) tick();
        wait_drain();
        order = '{1'b0, 1'b1, 1'b0};
        total++;
        if (cls_log.size() - start != 3) begin
            bad++;
            $display("FAIL prio_count: got=%0d required 3", cls_log.size() - start);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (cls_log[start + i] !== order[i]) begin
                    bad++;
                    $display("FAIL prio_order%0d: cls=%0d required %0d", i, cls_log[start + i], order[i]);
                end
            end
        end
    endtask

    task automatic test_error;
        int start;
        bus.o_ack = 1'b1;
        drive(1'b0, rnd72());
        tick();
        idle_in();
        total++;
        if (bus.ff_err !== 1'b1) begin bad++; $display("FAIL err_stray: got=%b required 1", bus.ff_err); end
        start = cls_log.size();
        send_pkt(1'b0, 12, 0);
        wait_drain();
        total++;
        if (cls_log.size() - start != 9) begin bad++; $display("FAIL err_len_clamp: words=%0d required 9", cls_log.size() - start); end
        total++;
        if (bus.ff_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got=%b required 1", bus.ff_err); end
        do_reset();
        total++;
        if (bus.ff_err !== 1'b0) begin bad++; $display("FAIL err_clear: got=%b required 0", bus.ff_err); end
    endtask

    task automatic test_random;
        int start;
        int words;
        bit c;
        int len;
        start    = cls_log.size();
        words    = 0;
        ack_rand = 1'b1;
        for (int p = 0; p < 100; p++) begin
            c   = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 8);
            repeat ($urandom_range(0, 3)) begin
                idle_in();
                tick();
            end
            send_pkt(c, len, 2);
            words += len + 1;
        end
        wait_drain();
        total++;
        if (cls_log.size() - start != words) begin
            bad++;
            $display("FAIL rand_count: got=%0d required %0d", cls_log.size() - start, words);
        end
        total++;
        if (bus.ff_err !== 1'b0) begin bad++; $display("FAIL rand_err: got=%b required 0", bus.ff_err); end
        total++;
        if (bus.i_rdyE !== 2'b11) begin bad++; $display("FAIL rand_rdyE: got=%b required 11", bus.i_rdyE); end
    endtask

    task automatic test_reset_mid;
        logic [71:0] d;
        int start;
        ack_rand  = 1'b0;
        bus.o_ack = 1'b1;
        d = rnd72();
        d[71:68] = 4'd5;
        d[67] = 1'b1;
        q1.push_back({2'b10, d});
        drive(1'b1, d);
        tick();
        for (int i = 0; i < 2; i++) begin
            d = rnd72();
            q1.push_back({2'b00, d});
            drive(1'b0, d);
            tick();
        end
        idle_in();
        rst = 1'b1;
        #1;
        total++;
        if ({bus.o_valid, bus.o_sof, bus.o_eof, bus.o_cls, bus.ff_err} !== 5'b0 || bus.o_data !== 72'h0) begin
            bad++;
            $display("FAIL mid_rst_out: ctrl=%b data=%h required 00000 0",
                     {bus.o_valid, bus.o_sof, bus.o_eof, bus.o_cls, bus.ff_err}, bus.o_data);
        end
        total++;
        if (bus.i_rdy !== 2'b00 || bus.i_rdyE !== 2'b11) begin
            bad++;
            $display("FAIL mid_rst_rdy: rdy=%b rdyE=%b required 00 11", bus.i_rdy, bus.i_rdyE);
        end
        tick();
        tick();
        q0.delete();
        q1.delete();
        rst = 1'b0;
        tick();
        total++;
        if (bus.i_rdy !== 2'b11) begin bad++; $display("FAIL mid_rdy_back: got=%b required 11", bus.i_rdy); end
        start = cls_log.size();
        send_pkt(1'b1, 4, 1);
        wait_drain();
        total++;
        if (cls_log.size() - start != 5) begin bad++; $display("FAIL mid_clean: words=%0d required 5", cls_log.size() - start); end
        total++;
        if (bus.ff_err !== 1'b0) begin bad++; $display("FAIL mid_err: got=%b required 0", bus.ff_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_priority();
        test_error();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
